// File: rtl/abc_stim_pkg.sv
// rtl/abc_stim_pkg.sv - shared types and constants for the a/b/c stimulus generator
package abc_stim_pkg;

   typedef enum logic {MANUAL, AUTO} stim_state_t;

   typedef logic [2:0] pattern_t;

   localparam pattern_t PATTERN_LAST = 3'b111;

endpackage

// File: rtl/btn_debounce.sv
// rtl/btn_debounce.sv - push-button debouncer with press-edge output
// Optional SYNC_EN adds a 2-flop synchronizer in front of the debouncer.
module btn_debounce #(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw,
   output logic level,
   output logic press
);

   localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             sample;
   logic             stable;
   logic             stable_q;
   logic [CNT_W-1:0] cnt;

`ifdef SYNC_EN
   logic [1:0] sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= 2'b00;
      end else begin
         sync_q <= {sync_q[0], raw};
      end
   end

   assign sample = sync_q[1];
`else
   assign sample = raw;
`endif

   // A new level is accepted only after it differs on DEBOUNCE_CYCLES consecutive edges.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         stable   <= 1'b0;
         stable_q <= 1'b0;
         cnt      <= '0;
      end else begin
         stable_q <= stable;
         if (sample != stable) begin
            if (cnt == CNT_LAST) begin
               stable <= sample;
               cnt    <= '0;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end else begin
            cnt <= '0;
         end
      end
   end

   assign level = stable;
   assign press = stable & ~stable_q;

endmodule

// File: rtl/abc_stim_gen.sv
// rtl/abc_stim_gen.sv - debounced manual/auto stepping generator for {a,b,c}
// Build option SYNC_EN enables input synchronizers inside btn_debounce.
module abc_stim_gen
   import abc_stim_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int AUTO_PERIOD     = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn_step,
   input  logic btn_mode,
   output logic a,
   output logic b,
   output logic c,
   output logic step_pulse,
   output logic sweep_done,
   output logic auto_on
);

   localparam int TICK_W = $clog2(AUTO_PERIOD);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(AUTO_PERIOD - 1);

   logic              step_level;
   logic              step_press;
   logic              mode_level;
   logic              mode_press;

   stim_state_t       state;
   stim_state_t       state_next;
   logic [TICK_W-1:0] tick;
   logic [TICK_W-1:0] tick_next;
   pattern_t          pat;
   logic              advance;
   logic              auto_q;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_step),
      .level (step_level),
      .press (step_press)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_mode_db (
      .clk   (clk),
      .rst_n (rst_n),
      .raw   (btn_mode),
      .level (mode_level),
      .press (mode_press)
   );

   // Mode events take priority over both step events and tick expiry; pat holds on a toggle.
   always_comb begin
      state_next = state;
      tick_next  = tick;
      advance    = 1'b0;
      case (state)
         MANUAL: begin
            if (mode_press) begin
               state_next = AUTO;
               tick_next  = '0;
            end else if (step_press) begin
               advance = 1'b1;
            end
         end
         AUTO: begin
            if (mode_press) begin
               state_next = MANUAL;
               tick_next  = '0;
            end else if (tick == TICK_LAST) begin
               advance   = 1'b1;
               tick_next = '0;
            end else begin
               tick_next = tick + 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= MANUAL;
         tick       <= '0;
         pat        <= '0;
         step_pulse <= 1'b0;
         sweep_done <= 1'b0;
         auto_q     <= 1'b0;
      end else begin
         state      <= state_next;
         tick       <= tick_next;
         step_pulse <= advance;
         sweep_done <= advance && (pat == PATTERN_LAST);
         auto_q     <= (state_next == AUTO);
         if (advance) begin
            pat <= pat + 3'd1;
         end
      end
   end

   assign a       = pat[2];
   assign b       = pat[1];
   assign c       = pat[0];
   assign auto_on = auto_q;

endmodule

// File: doc/abc_stim_gen.md
Name: abc_stim_gen

Overview:
- Upstream input stage for the 3-input/2-output combinational lab block (inputs a, b, c).
- Turns two raw push-buttons into a clean stepping sequence over all 8 {a,b,c} combinations.
- Supports manual single-step and timed auto-sweep modes, so the downstream logic can be exercised on the board with no external stimulus.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive cycles a raw button must hold a new level before it is accepted (min 2).
- AUTO_PERIOD, 8: clock cycles between pattern advances in auto mode (min 2).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- btn_step  in  1  raw step push-button, active-high, may bounce
- btn_mode  in  1  raw mode push-button, active-high, may bounce
- a  out  1  pattern MSB
- b  out  1  pattern middle bit
- c  out  1  pattern LSB
- step_pulse  out  1  one-cycle high on every pattern change
- sweep_done  out  1  one-cycle high when pattern wraps 111->000
- auto_on  out  1  high while in AUTO state

Behaviour:
- Single clock domain on clk. rst_n is asynchronous active-low. All flops clear immediately on rst_n=0.
- Reset values: a=b=c=0, step_pulse=0, sweep_done=0, auto_on=0, FSM=MANUAL, debounced levels=0, all counters=0.
- Debouncer, one per button:
  - Holds a stable level and a counter of width clog2(DEBOUNCE_CYCLES).
  - When raw != stable, the counter increments. When raw == stable, the counter clears.
  - When the counter == DEBOUNCE_CYCLES-1 and raw != stable, stable <= raw and the counter clears.
  - Net effect: raw must differ on DEBOUNCE_CYCLES consecutive sampling edges.
- Press event: rising edge of the stable level (stable & ~stable_q). Each press produces exactly one event, whatever the hold time.
- Pattern register pat[2:0] drives a=pat[2], b=pat[1], c=pat[0] directly from flops.
- FSM states:
  - MANUAL: a step event advances pat. A mode event goes to AUTO.
  - AUTO: tick counter counts 0..AUTO_PERIOD-1. At AUTO_PERIOD-1, pat advances and tick clears. A step event is ignored. A mode event goes to MANUAL.
- Entering AUTO clears tick. The first auto advance occurs AUTO_PERIOD cycles after the transition edge.
- Advance: pat <= pat+1, modulo 8. 111 wraps to 000.
- step_pulse is registered and high in the same cycle pat shows its new value. sweep_done is likewise registered and high with pat==000 after a wrap.
- Latency, raw press to new pattern: DEBOUNCE_CYCLES+1 edges (debounce, then one edge for the pattern update).
- Simultaneous step event and mode event in one cycle: mode wins. The FSM toggles and pat holds.
- In AUTO, a mode event on the same cycle as a tick expiry: the FSM goes to MANUAL and pat holds.
- Reset mid-sweep or mid-debounce: everything returns to reset values. A button still held at release of reset is accepted as a new press after DEBOUNCE_CYCLES.
- auto_on = (state == AUTO), registered.

Optional Feature:
- SYNC_EN defined: each raw button passes through a 2-flop synchronizer (reset to 0) before the debouncer. Press-to-pattern latency becomes DEBOUNCE_CYCLES+3 edges.
- SYNC_EN undefined: raw buttons feed the debouncer directly. Latency is DEBOUNCE_CYCLES+1 edges. All other behaviour is identical.

Decomposition:
- Package abc_stim_pkg:
  - typedef enum logic {MANUAL, AUTO} stim_state_t
  - typedef logic [2:0] pattern_t
  - localparam PATTERN_LAST = 3'b111
- Sub-module btn_debounce (parameter DEBOUNCE_CYCLES; ports clk, rst_n, raw, level, press). Instantiated twice. Contains the SYNC_EN synchronizer.
- FSM, tick counter and pattern register stay in the top.

Test Plan:
All scenarios use DEBOUNCE_CYCLES=4, AUTO_PERIOD=3, SYNC_EN undefined, unless stated.
1. Reset then btn_step held high 10 cycles -> pat 000->001 exactly 5 edges after the rise, one step_pulse, no further change while held. Assert rst_n=0 mid-hold -> a=b=c=0 immediately.
2. Bounce: btn_step toggles 1,0,1,1,0 then holds 1 -> no advance until 4 consecutive highs, then a single advance to 001.
3. Eight clean step presses in MANUAL -> pat walks 001..111,000. sweep_done is high only on the cycle pat=000, coincident with the 8th step_pulse.
4. Mode press -> auto_on=1. pat advances every 3 cycles. Step presses during AUTO produce no extra advances. A second mode press -> auto_on=0 and pat frozen.
5. Step and mode debounced on the same cycle in MANUAL -> auto_on rises, pat unchanged, step_pulse stays 0.
6. SYNC_EN defined, repeat scenario 1 -> advance occurs 7 edges after the rise.
